// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits sent LSB first, optional parity bit, one or two
// stop bits. A single holding register lets the next byte be queued while a frame
// is on the line, so back-to-back frames go out with no idle gap between them.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [2:0]       data_idx_r;
  logic             stop_idx_r;
  logic [7:0]       shift_r;
  logic             parity_r;
  logic [7:0]       hold_r;
  logic             hold_full_r;
  logic             tx_r;
  logic             done_r;

  logic             accept_s;
  logic             bit_end_s;
  logic             last_stop_s;
  logic             hold_capture_s;

  // Parity over the data byte; odd parity inverts the plain XOR.
  function automatic logic frame_parity(input logic [7:0] data);
    frame_parity = (^data) ^ (PARITY_ODD != 0);
  endfunction

  assign accept_s       = valid && ~hold_full_r;
  assign bit_end_s      = (bit_cnt_r == BIT_LAST);
  assign last_stop_s    = (state_r == STOP) && bit_end_s && (stop_idx_r == STOP_LAST);
  // A byte arriving while a frame is on the line is parked in the holding
  // register, except at the final stop cycle where it goes straight to the shifter.
  assign hold_capture_s = (state_r != IDLE) && ~last_stop_s;

  assign ready = ~hold_full_r;
  assign busy  = (state_r != IDLE);
  assign tx    = tx_r;
  assign done  = done_r;

  // Frame sequencer: state, bit timing, shifter, holding register and the
  // registered tx/done outputs. tx is loaded with the value of the bit being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      data_idx_r  <= 3'd0;
      stop_idx_r  <= 1'b0;
      shift_r     <= 8'h00;
      parity_r    <= 1'b0;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      tx_r        <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;

      if (state_r == IDLE) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if (bit_end_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end

      if (accept_s && hold_capture_s) begin
        hold_r      <= din;
        hold_full_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (hold_full_r) begin
            shift_r     <= hold_r;
            parity_r    <= frame_parity(hold_r);
            hold_full_r <= 1'b0;
            state_r     <= START;
            tx_r        <= 1'b0;
          end else if (accept_s) begin
            shift_r  <= din;
            parity_r <= frame_parity(din);
            state_r  <= START;
            tx_r     <= 1'b0;
          end else begin
            tx_r <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r    <= DATA;
            data_idx_r <= 3'd0;
            tx_r       <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (data_idx_r == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_r <= PARITY;
                tx_r    <= parity_r;
              end else begin
                state_r    <= STOP;
                stop_idx_r <= 1'b0;
                tx_r       <= 1'b1;
              end
            end else begin
              data_idx_r <= data_idx_r + 3'd1;
              shift_r    <= {1'b0, shift_r[7:1]};
              tx_r       <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r    <= STOP;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            if (stop_idx_r != STOP_LAST) begin
              stop_idx_r <= stop_idx_r + 1'b1;
              tx_r       <= 1'b1;
            end else begin
              done_r <= 1'b1;
              if (hold_full_r) begin
                shift_r     <= hold_r;
                parity_r    <= frame_parity(hold_r);
                hold_full_r <= 1'b0;
                state_r     <= START;
                tx_r        <= 1'b0;
              end else if (accept_s) begin
                shift_r  <= din;
                parity_r <= frame_parity(din);
                state_r  <= START;
                tx_r     <= 1'b0;
              end else begin
                state_r <= IDLE;
                tx_r    <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four instances (plain, even parity, odd parity,
// two stop bits) share clk/rst/din; one is selected at a time. Expected frames are
// queued when a byte is accepted and checked bit-by-bit, cycle-by-cycle on tx.
module tb_uart_transmitter;

  localparam int CPB = 4;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  int pe_of [4];
  int po_of [4];
  int sb_of [4];

  int     n_compared;
  int     n_mismatched;
  int     cur;
  int     ncyc;
  int     acc_n;
  int     done_n;
  int     done_cnt;
  int     busy_cnt;
  int     last_start_n;
  int     bit_cyc;
  logic   in_frame;
  logic   done_due;
  frame_t exp_f;
  frame_t sb [$];

  uart_transmitter #(.CLKS_PER_BIT(CPB)) u0 (
    .clk(clk), .rst(rst), .din(din), .valid(valid_v[0]), .ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .din(din), .valid(valid_v[1]), .ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .din(din), .valid(valid_v[2]), .ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .din(din), .valid(valid_v[3]), .ready(ready_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop bits of 1.
  function automatic frame_t make_frame(input logic [7:0] d, input int pe, input int po, input int sbits);
    frame_t f;
    f.bits      = 12'hFFF;
    f.bits[0]   = 1'b0;
    f.bits[8:1] = d;
    if (pe != 0) begin
      f.bits[9] = (^d) ^ (po != 0);
    end
    f.nbits = 10 + pe + sbits - 1;
    return f;
  endfunction

  // Monitor on the falling edge: done timing, busy count, frame start and tx bits.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      in_frame = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        check("done_pulse", done_v[cur], 1'b1);
        done_due = 1'b0;
      end else if (done_v[cur]) begin
        check("done_spurious", done_v[cur], 1'b0);
      end
      if (done_v[cur]) begin
        done_cnt++;
        done_n = ncyc;
      end
      if (busy_v[cur]) busy_cnt++;
      if (!in_frame && tx_v[cur] == 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_start", tx_v[cur], 1'b1);
        end else begin
          exp_f        = sb.pop_front();
          in_frame     = 1'b1;
          bit_cyc      = 0;
          last_start_n = ncyc;
        end
      end
      if (in_frame) begin
        check("tx_bit", tx_v[cur], exp_f.bits[bit_cyc / CPB]);
        bit_cyc++;
        if (bit_cyc == exp_f.nbits * CPB) begin
          in_frame = 1'b0;
          done_due = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int waits);
    waits = 0;
    din = b;
    valid_v[cur] = 1'b1;
    while (ready_v[cur] == 1'b0 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) begin
      check("accept_timeout", ready_v[cur], 1'b1);
    end else begin
      @(posedge clk);
      sb.push_back(make_frame(b, pe_of[cur], po_of[cur], sb_of[cur]));
      acc_n = ncyc + 1;
      #1;
    end
    valid_v[cur] = 1'b0;
    din = ~b;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy_v[cur] || in_frame || done_due) && n < 300);
    if (n >= 300) check("idle_timeout", busy_v[cur], 1'b0);
  endtask

  task automatic single_frame(input int inst, input logic [7:0] b, input int len);
    int w;
    cur = inst;
    busy_cnt = 0;
    send(b, w);
    wait_idle();
    check("frame_busy_cycles", busy_cnt, len);
    check("frame_done_offset", done_n - acc_n, len);
    check("frame_start_latency", last_start_n - acc_n, 0);
  endtask

  initial begin
    int w;
    int dc0;
    int early_ready;
    int n;
    pe_of = '{0, 1, 1, 0};
    po_of = '{0, 0, 1, 0};
    sb_of = '{1, 1, 1, 2};
    n_compared = 0; n_mismatched = 0; ncyc = 0; cur = 0;
    done_cnt = 0; busy_cnt = 0; done_n = 0; acc_n = 0; last_start_n = 0;
    in_frame = 1'b0; done_due = 1'b0; bit_cyc = 0;
    rst = 1'b1; din = 8'h00; valid_v = 4'h0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx_v, 4'hF);
    check("rst_busy", busy_v, 4'h0);
    check("rst_done", done_v, 4'h0);
    check("rst_ready", ready_v, 4'hF);

    // First byte goes in on the first edge after reset release.
    #1 rst = 1'b0;
    cur = 0;
    busy_cnt = 0;
    send(8'hA5, w);
    check("accept_first_edge", w, 0);
    wait_idle();
    check("a5_busy_cycles", busy_cnt, 40);
    check("a5_done_offset", done_n - acc_n, 40);
    check("a5_start_latency", last_start_n - acc_n, 0);

    single_frame(1, 8'hA5, 44);
    single_frame(2, 8'hA5, 44);
    single_frame(3, 8'h00, 44);
    single_frame(2, 8'h37, 44);

    // Back-to-back: second byte parked in the holding register.
    cur = 0;
    dc0 = done_cnt;
    send(8'h01, w);
    send(8'hFF, w);
    check("b2b_second_accept_wait", w, 0);
    @(negedge clk);
    #1;
    check("b2b_ready_low", ready_v[0], 1'b0);
    early_ready = 0;
    n = 0;
    while (done_cnt == dc0 && n < 100) begin
      if (ready_v[0]) early_ready++;
      @(negedge clk);
      #1;
      n++;
    end
    check("b2b_ready_low_while_held", early_ready, 0);
    check("b2b_first_done", done_cnt - dc0, 1);
    check("b2b_ready_back", ready_v[0], 1'b1);
    check("b2b_no_gap", last_start_n, done_n);
    wait_idle();
    check("b2b_done_count", done_cnt - dc0, 2);

    // Reset during DATA with the holding register full.
    cur = 0;
    dc0 = done_cnt;
    send(8'h3C, w);
    send(8'h99, w);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_tx", tx_v[0], 1'b1);
    check("rstmid_ready", ready_v[0], 1'b1);
    check("rstmid_busy", busy_v[0], 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("rstmid_no_done", done_cnt - dc0, 0);
    single_frame(0, 8'h5A, 40);

    // Idle line with valid low.
    cur = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      check("idle_line", {tx_v[0], busy_v[0], done_v[0]}, 3'b100);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
